// File: rtl/jk_ff_checker.sv
// Lockstep checker for a bank of JK flip-flops: models the bank and flags any divergence.
// Define JKCHK_TOGGLE_CNT_EN to build the toggle-cycle counter behind tgl_cnt (tied to 0 otherwise).

module jk_ff_checker #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dut_rst,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q,
    output logic             err,
    output logic             err_sticky,
    output logic [WIDTH-1:0] err_mask,
    output logic [7:0]       err_cnt,
    output logic [15:0]      chk_cnt,
    output logic [1:0]       state,
    output logic [7:0]       tgl_cnt
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSync  = 2'd1,
        StCheck = 2'd2,
        StHalt  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [15:0]      chk_cnt_q, chk_cnt_d;

    logic             compare;
    logic             mismatch;
    logic [WIDTH-1:0] diff;

    // Next value of a JK bank; the synchronous reset dominates J/K.
    function automatic logic [WIDTH-1:0] jk_next(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] jv,
        input logic [WIDTH-1:0] kv,
        input logic             rv
    );
        logic [WIDTH-1:0] nxt;
        nxt = (jv & ~cur) | (~kv & cur);
        if (rv) begin
            nxt = '0;
        end
        return nxt;
    endfunction

    assign compare  = (state_q == StCheck);
    assign diff     = q ^ m_q;
    assign mismatch = compare && (|diff);

    always_comb begin : next_state
        state_d = state_q;
        m_d     = m_q;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StSync;
                end
            end
            StSync: begin
                // Seed the model from the live bank so it resynchronises on every re-enable.
                state_d = StCheck;
                m_d     = jk_next(q, j, k, dut_rst);
            end
            StCheck: begin
                m_d = jk_next(m_q, j, k, dut_rst);
                if (!en) begin
                    state_d = StIdle;
                end else if (mismatch && (STOP_ON_ERR != 0)) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (!en) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin : status_next
        err_d     = mismatch;
        sticky_d  = sticky_q | mismatch;
        mask_d    = mask_q;
        err_cnt_d = err_cnt_q;
        chk_cnt_d = chk_cnt_q;
        if (mismatch) begin
            mask_d = diff;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
        if (compare && (chk_cnt_q != 16'hFFFF)) begin
            chk_cnt_d = chk_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            m_q       <= '0;
            err_q     <= 1'b0;
            sticky_q  <= 1'b0;
            mask_q    <= '0;
            err_cnt_q <= 8'd0;
            chk_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            err_q     <= err_d;
            sticky_q  <= sticky_d;
            mask_q    <= mask_d;
            err_cnt_q <= err_cnt_d;
            chk_cnt_q <= chk_cnt_d;
        end
    end

    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign err_mask   = mask_q;
    assign err_cnt    = err_cnt_q;
    assign chk_cnt    = chk_cnt_q;
    assign state      = state_q;

`ifdef JKCHK_TOGGLE_CNT_EN
    logic       tgl_prev_q, tgl_prev_d;
    logic [7:0] tgl_cnt_q, tgl_cnt_d;

    // A comparison counts as a toggle cycle when J=K=1 on any bit at the edge before it.
    always_comb begin : toggle_next
        tgl_prev_d = |(j & k);
        tgl_cnt_d  = tgl_cnt_q;
        if (compare && tgl_prev_q && (tgl_cnt_q != 8'hFF)) begin
            tgl_cnt_d = tgl_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgl_prev_q <= 1'b0;
            tgl_cnt_q  <= 8'd0;
        end else begin
            tgl_prev_q <= tgl_prev_d;
            tgl_cnt_q  <= tgl_cnt_d;
        end
    end

    assign tgl_cnt = tgl_cnt_q;
`else
    assign tgl_cnt = 8'd0;
`endif

endmodule

// File: doc/jk_ff_checker.md
JK_FF_CHECKER -- requirements
Module: jk_ff_checker

Interface
REQ-001 The module SHALL have parameter WIDTH, default 1, giving the number of JK flip-flop bits observed in parallel.
REQ-002 The module SHALL have parameter STOP_ON_ERR, default 0; when 1, checking halts at the first mismatch.
REQ-003 clk  input  1  single clock, rising edge active; same clock as the observed flip-flop bank.
REQ-004 rst_n  input  1  asynchronous active-low reset of the checker.
REQ-005 en  input  1  checking enable.
REQ-006 dut_rst  input  1  observed synchronous active-high reset of the flip-flop bank.
REQ-007 j  input  WIDTH  J inputs applied to the bank.
REQ-008 k  input  WIDTH  K inputs applied to the bank.
REQ-009 q  input  WIDTH  observed bank outputs.
REQ-010 err  output  1  one-cycle mismatch pulse.
REQ-011 err_sticky  output  1  latched mismatch flag.
REQ-012 err_mask  output  WIDTH  bits that mismatched at the last error.
REQ-013 err_cnt  output  8  saturating mismatch count.
REQ-014 chk_cnt  output  16  saturating count of compared cycles.
REQ-015 state  output  2  FSM state: IDLE=0, SYNC=1, CHECK=2, HALT=3.
REQ-016 tgl_cnt  output  8  saturating count of toggle (J=K=1) cycles.

Function
REQ-017 The module SHALL keep an internal model register m[WIDTH].
REQ-018 m SHALL update at every rising edge of clk in SYNC and CHECK, per bit:
- dut_rst=1 gives 0.
- J=0,K=0 gives hold.
- J=0,K=1 gives 0.
- J=1,K=0 gives 1.
- J=1,K=1 gives invert.
REQ-019 FSM transitions, evaluated at each rising edge:
- IDLE to SYNC when en=1.
- SYNC to CHECK unconditionally, loading m from q combined with that edge's j, k and dut_rst.
- CHECK to IDLE when en=0.
- CHECK to HALT on a mismatch when STOP_ON_ERR=1.
- HALT to IDLE when en=0.
REQ-020 In CHECK, at each rising edge the module SHALL compare q against m, using values held before the edge.
- A mismatch occurs when q differs from m.
- Any mismatching bit SHALL register err=1 for exactly one cycle and set err_sticky.
- The same event SHALL load err_mask with the XOR of q and m, and increment err_cnt.
REQ-021 chk_cnt SHALL increment once per CHECK-state comparison, saturating at 65535.
REQ-022 err_cnt SHALL saturate at 255. A further mismatch SHALL still pulse err and update err_mask.
REQ-023 No comparison SHALL occur in IDLE, SYNC or HALT.
REQ-024 err SHALL be 0 in those states.
REQ-025 err_sticky, err_mask, err_cnt and chk_cnt SHALL hold across IDLE. They clear only on rst_n.
REQ-026 Re-enabling from IDLE SHALL always pass through SYNC, so the model resynchronises to the live bank.
REQ-027 If en falls in the same cycle as a mismatch in CHECK, the mismatch SHALL still be recorded, and the next state SHALL be IDLE.
REQ-028 dut_rst asserted while in CHECK SHALL be modelled per REQ-018 and SHALL NOT be treated as an error.

Reset
REQ-029 rst_n=0 SHALL immediately clear all outputs and m to 0, and force state to IDLE, regardless of clk.
REQ-030 Release of rst_n SHALL take effect on the first rising edge of clk after deassertion.

Configuration
REQ-031 Macro JKCHK_TOGGLE_CNT_EN controls toggle counting.
- When defined, tgl_cnt SHALL increment, saturating at 255, once per CHECK comparison in which any bit had J=K=1 at the previous edge.
- When not defined, tgl_cnt SHALL be tied to 0, and no counter logic SHALL be present.
- The port SHALL exist in both builds.

Verification
REQ-032 Scenario 1: WIDTH=1, en=1, correct bank driven J,K=(1,0),(1,1),(0,1),(1,0),(0,1),(1,1),(1,0). Required: err never 1, err_cnt=0, and chk_cnt=6 after the sequence.
REQ-033 Scenario 2: a stuck-at-0 bank is driven J,K=1,0 in CHECK. Required: err pulses 1 cycle later, err_mask=1, err_sticky=1, err_cnt=1.
REQ-034 Scenario 3: STOP_ON_ERR=1 with repeated mismatches. Required: state=3 after the first mismatch, err_cnt stays at 1, and state returns to 0 when en=0.
REQ-035 Scenario 4: rst_n pulsed low mid-clock-period while err_cnt=5. Required: all outputs become 0 before the next edge, and state=0.
REQ-036 Scenario 5: WIDTH=4, bit 2 of the bank is inverted, 300 cycles. Required: err_cnt=255 (saturated), err_mask=4'b0100.
REQ-037 Scenario 6: with JKCHK_TOGGLE_CNT_EN defined, apply 3 toggle cycles. Required: tgl_cnt=3. Without the macro, tgl_cnt=0.
